// File: rtl/rx_tlp_sender.sv
// RX TLP sender: drains the RX packet buffer into 64-bit-address MWr TLPs on the TRN TX port,
// and on a page change writes the status qword, releases the huge page and restarts its offset.
module rx_tlp_sender #(
    parameter int unsigned BUF_AW = 10
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              trigger_tlp,
    output logic              trigger_tlp_ack,
    input  logic              change_huge_page,
    output logic              change_huge_page_ack,
    input  logic              send_last_tlp_change_huge_page,
    input  logic [4:0]        qwords_to_send,
    input  logic [63:0]       hp_base_addr,
    input  logic              hp_valid,
    output logic              hp_release,
    input  logic [15:0]       cfg_completer_id,
    output logic [BUF_AW-1:0] rd_addr,
    input  logic [63:0]       rd_data,
    output logic [BUF_AW-1:0] commited_rd_address,
    output logic [63:0]       trn_td,
    output logic              trn_tsof_n,
    output logic              trn_teof_n,
    output logic              trn_tsrc_rdy_n,
    output logic [7:0]        trn_trem_n,
    input  logic              trn_tdst_rdy_n,
    input  logic [5:0]        trn_tbuf_av
);

    localparam logic [3:0] IDLE    = 4'd0;
    localparam logic [3:0] HDR0    = 4'd1;
    localparam logic [3:0] HDR1    = 4'd2;
    localparam logic [3:0] DATA    = 4'd3;
    localparam logic [3:0] S_HDR0  = 4'd4;
    localparam logic [3:0] S_HDR1  = 4'd5;
    localparam logic [3:0] S_DATA  = 4'd6;
    localparam logic [3:0] RELEASE = 4'd7;
    localparam logic [3:0] ACK     = 4'd8;

    localparam logic [21:0] HP_OFF_START = 22'h00_0080;

    function automatic logic [63:0] mwr_hdr(input logic [4:0] qw, input logic [15:0] cid);
        mwr_hdr = {1'b0, 2'b11, 5'b0, 8'h00, 6'h00, {4'b0, qw, 1'b0}, cid, 8'h00, 4'hF, 4'hF};
    endfunction

    // request synchronizers and per-request parameter capture
    logic [1:0]        r_trig_sync;
    logic [1:0]        r_chp_sync;
    logic              r_trig_seen;
    logic              r_chp_seen;
    logic [4:0]        r_trig_qw;
    logic [4:0]        r_chp_qw;
    logic              r_chp_last;

    logic [3:0]        r_state;
    logic              r_serve_chp;
    logic [4:0]        r_cur_qw;
    logic [4:0]        r_dat_left;
    logic              r_trig_ack;
    logic              r_chp_ack;
    logic              r_hp_release;
    logic [21:0]       r_hp_off;
    logic [21:0]       r_bytes_used;
    logic [BUF_AW-1:0] r_commited;

    logic [63:0]       r_td;
    logic              r_sof_n;
    logic              r_eof_n;
    logic              r_src_rdy_n;

    logic [BUF_AW-1:0] r_rd_addr;
    logic [BUF_AW-1:0] r_next_rd;
    logic [4:0]        r_rd_left;
    logic              r_rd_vld0;
    logic              r_rd_vld1;
    logic [63:0]       r_fifo [4];
    logic [1:0]        r_fifo_wp;
    logic [1:0]        r_fifo_rp;
    logic [2:0]        r_fifo_cnt;

    logic              w_trig_s;
    logic              w_chp_s;
    logic              w_trig_first;
    logic              w_chp_first;
    logic [4:0]        w_trig_qw;
    logic [4:0]        w_chp_qw;
    logic              w_chp_last;
    logic              w_can_start;
    logic              w_trig_go;
    logic              w_chp_go;
    logic              w_go_data;
    logic [4:0]        w_go_qw;
    logic              w_acc;
    logic              w_slot;
    logic [2:0]        w_occ;
    logic              w_issue;
    logic [4:0]        w_rd_left_nx;
    logic              w_have;
    logic [63:0]       w_head;
    logic              w_pop;
    logic              w_fifo_pop;
    logic              w_push;
    logic [63:0]       w_data_addr;

    logic [3:0]        w_state_nx;
    logic [63:0]       w_td_nx;
    logic              w_sof_nx;
    logic              w_eof_nx;
    logic              w_rdy_nx;
    logic [4:0]        w_dat_left_nx;
    logic              w_eof_done;
    logic              w_release_nx;
    logic              w_hp_reset;
    logic              w_trig_ack_nx;
    logic              w_chp_ack_nx;

    assign w_trig_s     = r_trig_sync[1];
    assign w_chp_s      = r_chp_sync[1];
    assign w_trig_first = w_trig_s && !r_trig_seen;
    assign w_chp_first  = w_chp_s && !r_chp_seen;
    assign w_trig_qw    = w_trig_first ? qwords_to_send : r_trig_qw;
    assign w_chp_qw     = w_chp_first ? qwords_to_send : r_chp_qw;
    assign w_chp_last   = w_chp_first ? send_last_tlp_change_huge_page : r_chp_last;

    assign w_can_start = (r_state == IDLE) && !r_trig_ack && !r_chp_ack && hp_valid &&
                         (trn_tbuf_av != 6'd0);
    assign w_trig_go   = w_can_start && w_trig_s;
    assign w_chp_go    = w_can_start && !w_trig_s && w_chp_s;
    assign w_go_data   = w_trig_go || (w_chp_go && w_chp_last);
    assign w_go_qw     = w_trig_go ? w_trig_qw : w_chp_qw;

    assign w_acc  = !r_src_rdy_n && !trn_tdst_rdy_n;
    assign w_slot = r_src_rdy_n || w_acc;

    // Reads are issued ahead of the TX beats; in-flight reads plus queued data never exceed
    // the 4-entry queue, so stalls on the TRN side cannot drop a returning qword.
    assign w_occ   = r_fifo_cnt + {2'b0, r_rd_vld0} + {2'b0, r_rd_vld1};
    assign w_issue = w_go_data || ((r_rd_left != 5'd0) && (w_occ < 3'd4));

    always_comb begin
        w_rd_left_nx = r_rd_left;
        if (w_go_data) begin
            w_rd_left_nx = w_go_qw - 5'd1;
        end else if (w_issue) begin
            w_rd_left_nx = r_rd_left - 5'd1;
        end
    end

    assign w_have      = (r_fifo_cnt != 3'd0) || r_rd_vld1;
    assign w_head      = (r_fifo_cnt != 3'd0) ? r_fifo[r_fifo_rp] : rd_data;
    assign w_fifo_pop  = w_pop && (r_fifo_cnt != 3'd0);
    assign w_push      = r_rd_vld1 && !(w_pop && (r_fifo_cnt == 3'd0));
    assign w_data_addr = hp_base_addr + {42'b0, r_hp_off[21:2], 2'b00};

    always_comb begin
        w_state_nx    = r_state;
        w_td_nx       = r_td;
        w_sof_nx      = r_sof_n;
        w_eof_nx      = r_eof_n;
        w_rdy_nx      = r_src_rdy_n;
        w_dat_left_nx = r_dat_left;
        w_pop         = 1'b0;
        w_eof_done    = 1'b0;
        w_release_nx  = 1'b0;
        w_hp_reset    = 1'b0;
        w_trig_ack_nx = r_trig_ack;
        w_chp_ack_nx  = r_chp_ack;
        case (r_state)
            IDLE: begin
                if (w_trig_go || w_chp_go) begin
                    w_rdy_nx = 1'b0;
                    w_sof_nx = 1'b0;
                    w_eof_nx = 1'b1;
                    if (w_go_data) begin
                        w_td_nx       = mwr_hdr(w_go_qw, cfg_completer_id);
                        w_dat_left_nx = w_go_qw;
                        w_state_nx    = HDR0;
                    end else begin
                        w_td_nx    = mwr_hdr(5'd1, cfg_completer_id);
                        w_state_nx = S_HDR0;
                    end
                end
            end
            HDR0: begin
                if (w_acc) begin
                    w_td_nx    = w_data_addr;
                    w_sof_nx   = 1'b1;
                    w_state_nx = HDR1;
                end
            end
            HDR1, DATA: begin
                if (w_acc && !r_eof_n) begin
                    w_eof_done = 1'b1;
                    w_eof_nx   = 1'b1;
                    if (r_serve_chp) begin
                        w_td_nx    = mwr_hdr(5'd1, cfg_completer_id);
                        w_sof_nx   = 1'b0;
                        w_state_nx = S_HDR0;
                    end else begin
                        w_rdy_nx      = 1'b1;
                        w_trig_ack_nx = 1'b1;
                        w_state_nx    = ACK;
                    end
                end else if (w_slot && (r_dat_left != 5'd0)) begin
                    w_state_nx = DATA;
                    w_sof_nx   = 1'b1;
                    if (w_have) begin
                        w_pop         = 1'b1;
                        w_td_nx       = w_head;
                        w_rdy_nx      = 1'b0;
                        w_eof_nx      = (r_dat_left != 5'd1);
                        w_dat_left_nx = r_dat_left - 5'd1;
                    end else begin
                        w_rdy_nx = 1'b1;
                    end
                end
            end
            S_HDR0: begin
                if (w_acc) begin
                    w_td_nx    = {hp_base_addr[63:2], 2'b00};
                    w_sof_nx   = 1'b1;
                    w_state_nx = S_HDR1;
                end
            end
            S_HDR1: begin
                if (w_acc) begin
                    w_td_nx    = {10'b0, r_bytes_used, 32'h0000_0001};
                    w_eof_nx   = 1'b0;
                    w_state_nx = S_DATA;
                end
            end
            S_DATA: begin
                if (w_acc) begin
                    w_rdy_nx     = 1'b1;
                    w_eof_nx     = 1'b1;
                    w_release_nx = 1'b1;
                    w_state_nx   = RELEASE;
                end
            end
            RELEASE: begin
                w_hp_reset   = 1'b1;
                w_chp_ack_nx = 1'b1;
                w_state_nx   = ACK;
            end
            ACK: begin
                if (r_serve_chp ? !w_chp_s : !w_trig_s) begin
                    w_trig_ack_nx = 1'b0;
                    w_chp_ack_nx  = 1'b0;
                    w_state_nx    = IDLE;
                end
            end
            default: begin
                w_state_nx = IDLE;
                w_rdy_nx   = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_trig_sync  <= 2'b00;
            r_chp_sync   <= 2'b00;
            r_trig_seen  <= 1'b0;
            r_chp_seen   <= 1'b0;
            r_trig_qw    <= 5'd0;
            r_chp_qw     <= 5'd0;
            r_chp_last   <= 1'b0;
            r_state      <= IDLE;
            r_serve_chp  <= 1'b0;
            r_cur_qw     <= 5'd0;
            r_dat_left   <= 5'd0;
            r_trig_ack   <= 1'b0;
            r_chp_ack    <= 1'b0;
            r_hp_release <= 1'b0;
            r_hp_off     <= HP_OFF_START;
            r_bytes_used <= 22'd0;
            r_commited   <= '0;
            r_td         <= 64'd0;
            r_sof_n      <= 1'b1;
            r_eof_n      <= 1'b1;
            r_src_rdy_n  <= 1'b1;
            r_rd_addr    <= '0;
            r_next_rd    <= '0;
            r_rd_left    <= 5'd0;
            r_rd_vld0    <= 1'b0;
            r_rd_vld1    <= 1'b0;
            r_fifo_wp    <= 2'd0;
            r_fifo_rp    <= 2'd0;
            r_fifo_cnt   <= 3'd0;
        end else begin
            r_trig_sync <= {r_trig_sync[0], trigger_tlp};
            r_chp_sync  <= {r_chp_sync[0], change_huge_page};
            r_trig_seen <= w_trig_s;
            r_chp_seen  <= w_chp_s;
            if (w_trig_first) begin
                r_trig_qw <= qwords_to_send;
            end
            if (w_chp_first) begin
                r_chp_qw   <= qwords_to_send;
                r_chp_last <= send_last_tlp_change_huge_page;
            end

            r_state      <= w_state_nx;
            r_td         <= w_td_nx;
            r_sof_n      <= w_sof_nx;
            r_eof_n      <= w_eof_nx;
            r_src_rdy_n  <= w_rdy_nx;
            r_dat_left   <= w_dat_left_nx;
            r_trig_ack   <= w_trig_ack_nx;
            r_chp_ack    <= w_chp_ack_nx;
            r_hp_release <= w_release_nx;
            if (w_trig_go || w_chp_go) begin
                r_serve_chp <= w_chp_go;
                r_cur_qw    <= w_go_qw;
            end

            if (w_eof_done) begin
                r_hp_off     <= r_hp_off + {14'b0, r_cur_qw, 3'b000};
                r_bytes_used <= r_bytes_used + {14'b0, r_cur_qw, 3'b000};
                r_commited   <= r_commited + BUF_AW'(r_cur_qw);
            end else if (w_hp_reset) begin
                r_hp_off     <= HP_OFF_START;
                r_bytes_used <= 22'd0;
            end

            r_rd_left <= w_rd_left_nx;
            r_rd_vld0 <= w_issue;
            r_rd_vld1 <= r_rd_vld0;
            if (w_issue) begin
                r_rd_addr <= r_next_rd;
                r_next_rd <= r_next_rd + BUF_AW'(1);
            end
            if (w_push) begin
                r_fifo_wp <= r_fifo_wp + 2'd1;
            end
            if (w_fifo_pop) begin
                r_fifo_rp <= r_fifo_rp + 2'd1;
            end
            r_fifo_cnt <= r_fifo_cnt + {2'b0, w_push} - {2'b0, w_fifo_pop};
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo[r_fifo_wp] <= rd_data;
        end
    end

    assign trigger_tlp_ack      = r_trig_ack;
    assign change_huge_page_ack = r_chp_ack;
    assign hp_release           = r_hp_release;
    assign rd_addr              = r_rd_addr;
    assign commited_rd_address  = r_commited;
    assign trn_td               = r_td;
    assign trn_tsof_n           = r_sof_n;
    assign trn_teof_n           = r_eof_n;
    assign trn_tsrc_rdy_n       = r_src_rdy_n;
    assign trn_trem_n           = 8'h00;

endmodule

// File: tb/tb_rx_tlp_sender.sv
// Scoreboard bench for rx_tlp_sender: expected TRN beats are queued as requests are raised
// and popped as the sender's beats are accepted.
module tb_rx_tlp_sender;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        trigger_tlp;
    logic        trigger_tlp_ack;
    logic        change_huge_page;
    logic        change_huge_page_ack;
    logic        send_last;
    logic [4:0]  qwords_to_send;
    logic [63:0] hp_base_addr;
    logic        hp_valid;
    logic        hp_release;
    logic [15:0] cfg_completer_id;
    logic [9:0]  rd_addr;
    logic [63:0] rd_data;
    logic [9:0]  commited_rd_address;
    logic [63:0] trn_td;
    logic        trn_tsof_n;
    logic        trn_teof_n;
    logic        trn_tsrc_rdy_n;
    logic [7:0]  trn_trem_n;
    logic        trn_tdst_rdy_n;
    logic [5:0]  trn_tbuf_av;

    always #5 clk = ~clk;

    rx_tlp_sender #(.BUF_AW(10)) dut (
        .clk                            (clk),
        .reset_n                        (reset_n),
        .trigger_tlp                    (trigger_tlp),
        .trigger_tlp_ack                (trigger_tlp_ack),
        .change_huge_page               (change_huge_page),
        .change_huge_page_ack           (change_huge_page_ack),
        .send_last_tlp_change_huge_page (send_last),
        .qwords_to_send                 (qwords_to_send),
        .hp_base_addr                   (hp_base_addr),
        .hp_valid                       (hp_valid),
        .hp_release                     (hp_release),
        .cfg_completer_id               (cfg_completer_id),
        .rd_addr                        (rd_addr),
        .rd_data                        (rd_data),
        .commited_rd_address            (commited_rd_address),
        .trn_td                         (trn_td),
        .trn_tsof_n                     (trn_tsof_n),
        .trn_teof_n                     (trn_teof_n),
        .trn_tsrc_rdy_n                 (trn_tsrc_rdy_n),
        .trn_trem_n                     (trn_trem_n),
        .trn_tdst_rdy_n                 (trn_tdst_rdy_n),
        .trn_tbuf_av                    (trn_tbuf_av)
    );

    logic [63:0] mem [1024];
    always @(posedge clk) rd_data <= mem[rd_addr];

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_val(input string tag, input logic [65:0] got, input logic [65:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h expected=%h", tag, got, exp);
        end
    endtask

    // beat = {sof_n, eof_n, td}
    logic [65:0] exp_q [$];
    logic [65:0] beat;
    logic [65:0] exp_beat;
    int          cyc = 0;
    int          eof_cyc = 0;
    int          n_sof = 0;
    int          n_rel = 0;
    bit          bp = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (hp_release) n_rel++;
        if (!trn_tsrc_rdy_n && !trn_tdst_rdy_n) begin
            beat = {trn_tsof_n, trn_teof_n, trn_td};
            check_val("beat_expected", 66'(exp_q.size() != 0), 66'd1);
            if (exp_q.size() != 0) begin
                exp_beat = exp_q.pop_front();
                check_val("beat", beat, exp_beat);
            end
            if (!trn_tsof_n) n_sof++;
            if (!trn_teof_n) eof_cyc = cyc;
        end
    end

    initial begin
        trn_tdst_rdy_n = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            trn_tdst_rdy_n = bp ? ~trn_tdst_rdy_n : 1'b0;
        end
    end

    // reference model of page offset, bytes used and consumed qwords
    int m_off = 128;
    int m_bytes = 0;
    int m_rd = 0;

    function automatic logic [63:0] hdr(input int qw, input logic [15:0] cid);
        hdr = {32'h6000_0000 | 32'(2 * qw), cid, 16'h00FF};
    endfunction

    task automatic push_data(input int qw);
        exp_q.push_back({2'b01, hdr(qw, cfg_completer_id)});
        exp_q.push_back({2'b11, hp_base_addr + 64'(m_off)});
        for (int k = 0; k < qw; k++) begin
            exp_q.push_back({1'b1, (k == qw - 1) ? 1'b0 : 1'b1, mem[(m_rd + k) % 1024]});
        end
        m_off   += 8 * qw;
        m_bytes += 8 * qw;
        m_rd     = (m_rd + qw) % 1024;
    endtask

    task automatic push_status();
        exp_q.push_back({2'b01, hdr(1, cfg_completer_id)});
        exp_q.push_back({2'b11, hp_base_addr});
        exp_q.push_back({2'b10, 32'(m_bytes), 32'h0000_0001});
        m_off   = 128;
        m_bytes = 0;
    endtask

    task automatic wait_level(input string tag, input bit chp, input logic lvl, input int budget);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while ((chp ? change_huge_page_ack : trigger_tlp_ack) !== lvl && n < budget);
        check_val(tag, 66'(chp ? change_huge_page_ack : trigger_tlp_ack), 66'(lvl));
    endtask

    task automatic do_trigger(input int qw);
        @(negedge clk);
        qwords_to_send = 5'(qw);
        push_data(qw);
        trigger_tlp = 1'b1;
        wait_level("trig_ack_rise", 1'b0, 1'b1, 2000);
        check_val("ack_latency", 66'(cyc - eof_cyc), 66'd1);
        repeat (3) @(negedge clk);
        check_val("ack_hold", 66'(trigger_tlp_ack), 66'd1);
        check_val("commited", 66'(commited_rd_address), 66'(m_rd));
        check_val("beats_pending", 66'(exp_q.size()), 66'd0);
        trigger_tlp = 1'b0;
        wait_level("trig_ack_fall", 1'b0, 1'b0, 100);
    endtask

    task automatic check_idle_outputs(input string tag);
        check_val({tag, "_src_rdy"}, 66'(trn_tsrc_rdy_n), 66'd1);
        check_val({tag, "_sof"}, 66'(trn_tsof_n), 66'd1);
        check_val({tag, "_eof"}, 66'(trn_teof_n), 66'd1);
        check_val({tag, "_td"}, 66'(trn_td), 66'd0);
        check_val({tag, "_trig_ack"}, 66'(trigger_tlp_ack), 66'd0);
        check_val({tag, "_chp_ack"}, 66'(change_huge_page_ack), 66'd0);
        check_val({tag, "_release"}, 66'(hp_release), 66'd0);
        check_val({tag, "_rd_addr"}, 66'(rd_addr), 66'd0);
        check_val({tag, "_commited"}, 66'(commited_rd_address), 66'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    int s0;
    int r0;
    int n;

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 64'hC0DE_5A00_0000_0000 ^ 64'(i);
        reset_n          = 1'b0;
        trigger_tlp      = 1'b0;
        change_huge_page = 1'b0;
        send_last        = 1'b0;
        qwords_to_send   = 5'd0;
        hp_base_addr     = 64'h0000_0001_0000_0000;
        hp_valid         = 1'b1;
        cfg_completer_id = 16'h1234;
        trn_tbuf_av      = 6'd8;
        repeat (3) @(negedge clk);
        check_idle_outputs("reset");
        check_val("reset_trem", 66'(trn_trem_n), 66'd0);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);

        do_trigger(16);
        bp = 1'b1;
        do_trigger(16);
        do_trigger(16);
        check_val("commited_48", 66'(commited_rd_address), 66'd48);
        bp = 1'b0;

        // page change with a final 5-qword flush
        @(negedge clk);
        qwords_to_send   = 5'd5;
        send_last        = 1'b1;
        push_data(5);
        check_val("model_bytes", 66'(m_bytes), 66'h1A8);
        push_status();
        r0               = n_rel;
        change_huge_page = 1'b1;
        wait_level("chp_ack_rise", 1'b1, 1'b1, 2000);
        check_val("release_pulses", 66'(n_rel - r0), 66'd1);
        check_val("chp_beats_pending", 66'(exp_q.size()), 66'd0);
        check_val("chp_commited", 66'(commited_rd_address), 66'd53);
        check_val("chp_no_trig_ack", 66'(trigger_tlp_ack), 66'd0);
        change_huge_page = 1'b0;
        send_last        = 1'b0;
        wait_level("chp_ack_fall", 1'b1, 1'b0, 100);

        do_trigger(16);
        for (int i = 0; i < 59; i++) do_trigger(16);
        do_trigger(7);
        check_val("commited_1020", 66'(commited_rd_address), 66'd1020);
        do_trigger(8);
        check_val("commited_wrap", 66'(commited_rd_address), 66'd4);

        // gating on hp_valid and trn_tbuf_av
        @(negedge clk);
        hp_valid       = 1'b0;
        qwords_to_send = 5'd3;
        push_data(3);
        trigger_tlp    = 1'b1;
        s0             = n_sof;
        repeat (20) @(negedge clk);
        check_val("gate_hpv_sof", 66'(n_sof - s0), 66'd0);
        check_val("gate_hpv_ack", 66'(trigger_tlp_ack), 66'd0);
        hp_valid    = 1'b1;
        trn_tbuf_av = 6'd0;
        repeat (20) @(negedge clk);
        check_val("gate_buf_sof", 66'(n_sof - s0), 66'd0);
        check_val("gate_buf_ack", 66'(trigger_tlp_ack), 66'd0);
        trn_tbuf_av = 6'd8;
        wait_level("gate_ack_rise", 1'b0, 1'b1, 500);
        check_val("gate_sof", 66'(n_sof - s0), 66'd1);
        check_val("gate_commited", 66'(commited_rd_address), 66'(m_rd));
        trigger_tlp = 1'b0;
        wait_level("gate_ack_fall", 1'b0, 1'b0, 100);

        // reset in the middle of a data phase
        bp = 1'b1;
        @(negedge clk);
        qwords_to_send = 5'd16;
        push_data(16);
        trigger_tlp    = 1'b1;
        n = 0;
        while (exp_q.size() > 10 && n < 500) begin
            @(negedge clk);
            n++;
        end
        check_val("reached_data", 66'(exp_q.size() <= 10), 66'd1);
        @(posedge clk);
        #2;
        reset_n     = 1'b0;
        trigger_tlp = 1'b0;
        #1;
        check_idle_outputs("midreset");
        exp_q.delete();
        m_off   = 128;
        m_bytes = 0;
        m_rd    = 0;
        bp      = 1'b0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
        do_trigger(4);
        check_val("post_reset_commited", 66'(commited_rd_address), 66'd4);

        repeat (5) @(negedge clk);
        check_val("final_queue_empty", 66'(exp_q.size()), 66'd0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/rx_tlp_sender.md
Name: rx_tlp_sender

Overview:
- PCIe-clock-domain consumer of the RX trigger handshakes.
- On each trigger_tlp request it reads qwords_to_send qwords from the RX packet buffer and emits one 64-bit-address Memory Write TLP into the current huge page via the TRN transmit interface.
- On change_huge_page it can first flush a final partial TLP, then writes a status qword (bytes used) at page offset 0, releases the page and advances commited_rd_address.

Parameters:
- BUF_AW, 10, qword address width of the RX buffer; equals `BF+1.

Ports:
- clk  in  1  PCIe user clock
- reset_n  in  1  asynchronous, active-low reset
- trigger_tlp  in  1  request from the other clock domain; synchronized internally
- trigger_tlp_ack  out  1  4-phase acknowledge
- change_huge_page  in  1  request from the other domain
- change_huge_page_ack  out  1  4-phase acknowledge
- send_last_tlp_change_huge_page  in  1  flush a data TLP before closing the page; stable while change_huge_page is high
- qwords_to_send  in  5  payload size, 1..16; stable while a request is high
- hp_base_addr  in  64  current huge page byte address, 2MB aligned
- hp_valid  in  1  hp_base_addr is usable
- hp_release  out  1  one-cycle pulse: page closed
- cfg_completer_id  in  16  requester ID for TLP headers
- rd_addr  out  BUF_AW  buffer read address; data returns 1 cycle later
- rd_data  in  64  buffer read data
- commited_rd_address  out  BUF_AW  qwords consumed
- trn_td  out  64  TX data; DW0 is in [63:32]
- trn_tsof_n, trn_teof_n, trn_tsrc_rdy_n  out  1 each  TRN framing, active-low
- trn_trem_n  out  8  always 8'h00
- trn_tdst_rdy_n  in  1  TRN sink ready
- trn_tbuf_av  in  6  TX buffers available

Behaviour:
- Reset values:
  - trigger_tlp_ack=0, change_huge_page_ack=0, hp_release=0.
  - trn_tsof_n=trn_teof_n=trn_tsrc_rdy_n=1, trn_td=0.
  - rd_addr=0, commited_rd_address=0.
  - Internal page offset hp_off=0x80 bytes, bytes_used=0, FSM=IDLE.
- Reset mid-TLP aborts the packet and returns to these values.
- Synchronization:
  - trigger_tlp and change_huge_page each pass a 2-flop synchronizer (req_s).
  - qwords_to_send and send_last are sampled when req_s is first seen high.
- Handshake (per request):
  - A request starts only when req_s=1, its ack=0, FSM=IDLE, hp_valid=1 and trn_tbuf_av!=0.
  - ack rises 1 cycle after the last beat is accepted.
  - ack holds until req_s=0, then falls next cycle.
  - No new request is accepted while either ack is high.
  - If both req_s are high, trigger_tlp is served first.
- States: IDLE, HDR0, HDR1, DATA, S_HDR0, S_HDR1, S_DATA, RELEASE, ACK.
- Data TLP (trigger, or change_huge_page with send_last=1):
  - HDR0: trn_td={1'b0,2'b11,5'b0,8'h00,6'h00,len[9:0], cfg_completer_id,8'h00,4'hF,4'hF}, with len={qwords,1'b0} (qwords=16 gives len=32). tsof_n=0.
  - HDR1: trn_td=hp_base_addr+hp_off (bits[1:0]=0).
  - DATA: one beat per qword from rd_data; teof_n=0 on the last beat.
  - A beat advances only when tsrc_rdy_n=0 and tdst_rdy_n=0. trn_td and the framing signals hold otherwise.
  - The read pipeline absorbs stalls with no lost or duplicated qwords.
  - After EOF is accepted: hp_off+=8*qwords, bytes_used+=8*qwords, commited_rd_address+=qwords (mod 2^BUF_AW).
  - rd_addr wraps mod 2^BUF_AW.
  - A trigger request then goes to ACK. A change_huge_page request continues to S_HDR0.
- Status TLP (change_huge_page):
  - 1-qword MWr (len=2) to hp_base_addr+0.
  - Payload DW0=bytes_used, DW1=32'h0000_0001.
- RELEASE: hp_release pulses for 1 cycle; hp_off=0x80 and bytes_used=0; then go to ACK.
- ACK: assert the relevant ack and return to IDLE once req_s=0 and ack has dropped.
- No TLP may cross the 2MB page boundary; the upstream trigger logic guarantees this. hp_off never exceeds 0x200000.
- tsrc_rdy_n is continuous within a packet except for internal read bubbles, which are allowed only before SOF.

Test Plan:
- Reset, then trigger_tlp with qwords_to_send=16, hp_base=0x1_0000_0000, buffer holding 0..15:
  - HDR0 len=32, HDR1 addr=0x1_0000_0080, data beats 0..15.
  - commited_rd_address=16, then ack rises and falls after req drops.
- Two further 16-qword triggers with tdst_rdy_n toggling every other cycle:
  - addresses 0x...0100 and 0x...0180, no lost or duplicated data.
  - commited_rd_address=48.
- change_huge_page with send_last=1, qwords_to_send=5, after 48 qwords sent:
  - 5-qword TLP at 0x...0200 (len=10), then status TLP at offset 0 carrying DW0=0x1A8, DW1=1.
  - hp_release pulse; next TLP lands at offset 0x80.
- rd_addr starting at 1020 (BUF_AW=10), 8-qword trigger: reads wrap 1020..1023,0..3; commited_rd_address=4.
- hp_valid=0 or trn_tbuf_av=0 while trigger_tlp=1: no SOF and no ack until both are asserted.
- Reset asserted mid-DATA: framing returns to 1 immediately, ack=0; the next trigger starts from HDR0 with hp_off=0x80.
